lsu_bridge: RTL

//  Load/store unit between the core's data-memory port and the pmem DPI memory port in cpu.

---
 rtl/lsu_bridge.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_bridge.sv
// Load/store bridge from the core data port to the pmem port.
// Aligns sub-word accesses, waits LATENCY cycles, then strobes once.
module lsu_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 0,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic [3:0]            mem_mask,
  output logic [DATA_WIDTH-1:0] mem_w,
  input  logic [DATA_WIDTH-1:0] mem_r
);

  typedef enum logic [1:0] {
    IDLE, WAIT, ACCESS, RESP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAT_M1 =
    CNT_WIDTH'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wen_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q;

  logic                  req_err;
  logic                  accept;
  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] ld_sh;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [3:0]            base_mask;

  assign accept = (state_q == IDLE) && req_valid;
  assign sh     = {addr_q[1:0], 3'b000};
  assign ld_sh  = mem_r >> sh;

  always_comb begin
    req_err = 1'b1;
    unique case (req_funct3)
      3'b000, 3'b100: req_err = req_wen & req_funct3[2];
      3'b001, 3'b101: req_err = (req_wen & req_funct3[2]) | req_addr[0];
      3'b010:         req_err = |req_addr[1:0];
      default:        req_err = 1'b1;
    endcase
  end

  always_comb begin
    ld_ext = '0;
    unique case (f3_q)
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_ext = ld_sh;
      3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
      3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    base_mask = 4'b1111;
    unique case (f3_q[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      f3_q    <= 3'b000;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wen_q   <= req_wen;
        f3_q    <= req_funct3;
        err_q   <= req_err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          if (req_err) begin
            state_d = RESP;
          end else if (LATENCY == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACCESS: begin
        state_d = RESP;
        if (!wen_q) rdata_d = ld_ext;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are forced to zero outside the single ACCESS cycle.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_addr  = '0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_mask  = 4'b0000;
    mem_w     = '0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      WAIT: ;
      ACCESS: begin
        mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_r_en = ~wen_q;
        mem_w_en = wen_q;
        mem_mask = base_mask << addr_q[1:0];
        mem_w    = wdata_q << sh;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
